// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the button-to-TX scheduler: FSM states, button
// indices and the ASCII code emitted for each button.
package btn_ctrl_pkg;

  typedef enum logic {
    IDLE,
    PUSH
  } state_t;

  localparam logic [1:0] BTN_U = 2'd0;
  localparam logic [1:0] BTN_D = 2'd1;
  localparam logic [1:0] BTN_L = 2'd2;
  localparam logic [1:0] BTN_R = 2'd3;

  localparam logic [7:0] CODE_U = 8'h55;
  localparam logic [7:0] CODE_D = 8'h44;
  localparam logic [7:0] CODE_L = 8'h4C;
  localparam logic [7:0] CODE_R = 8'h52;

  function automatic logic [7:0] btn_code(input logic [1:0] idx);
    logic [7:0] code;
    case (idx)
      BTN_U:   code = CODE_U;
      BTN_D:   code = CODE_D;
      BTN_L:   code = CODE_L;
      default: code = CODE_R;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way combinational round-robin arbiter; search starts one past the
// previous grant and wraps from 3 to 0.
module rr_arb4 (
  input  logic [3:0] pending,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    grant = last_grant;
    valid = 1'b0;
    cand  = last_grant;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!valid && pending[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_tx_sched.sv
// Debounce tick generator plus round-robin scheduler that turns button
// edge pulses into single-byte TX FIFO writes.
module btn_tx_sched
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_pulse,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       db_tick,
  output logic [3:0] pending,
  output logic [7:0] drop_cnt
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign db_tick = (tick_cnt == TICK_LAST);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic [7:0] data_nxt;
  logic [3:0] clr;
  logic [1:0] arb_grant;
  logic       arb_valid;

  rr_arb4 u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    data_nxt       = tx_data;
    last_grant_nxt = last_grant;
    tx_push        = 1'b0;
    clr            = '0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          idx_nxt   = arb_grant;
          data_nxt  = btn_code(arb_grant);
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        tx_push = ~tx_full;
        if (!tx_full) begin
          clr[idx]       = 1'b1;
          last_grant_nxt = idx;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      tx_data    <= '0;
      last_grant <= BTN_R;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      tx_data    <= data_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // A pulse landing on the edge that clears its own request re-arms it and
  // is not counted as lost.
  logic [3:0] drops;
  logic [2:0] drop_n;
  logic [8:0] drop_sum;
  logic [7:0] drop_nxt;

  always_comb begin
    drops  = btn_pulse & pending & ~clr;
    drop_n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      drop_n = drop_n + 3'(drops[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 9'(drop_n);
    drop_nxt = drop_sum[8] ? '1 : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr) | btn_pulse;
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_btn_tx_sched.sv
// Directed self-checking bench for btn_tx_sched with TICK_DIV=4.
module tb_btn_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       db_tick;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  btn_tx_sched #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .tx_full   (tx_full),
    .tx_push   (tx_push),
    .tx_data   (tx_data),
    .db_tick   (db_tick),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    btn_pulse = '0;
    tx_full   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst       = 1'b1;
    btn_pulse = '0;
    tx_full   = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({tx_push, tx_data, db_tick, pending, drop_cnt} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: push=%b data=%h tick=%b pend=%b drop=%0d, want all 0",
               tx_push, tx_data, db_tick, pending, drop_cnt);
    end
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      exp_tick = (k == 3 || k == 7 || k == 11);
      n_checks++;
      if (db_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL db_tick cycle %0d: got %b want %b", k, db_tick, exp_tick);
      end
      n_checks++;
      if ({tx_push, tx_data, pending, drop_cnt} !== 21'd0) begin
        n_fail++;
        $display("FAIL idle_outputs cycle %0d: push=%b data=%h pend=%b drop=%0d, want 0",
                 k, tx_push, tx_data, pending, drop_cnt);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    btn_pulse = 4'b0100;
    tick();
    btn_pulse = '0;
    n_checks++;
    if (pending !== 4'b0100 || tx_push !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1: pend=%b push=%b want 0100/0", pending, tx_push);
    end
    tick();
    n_checks++;
    if (tx_push !== 1'b1 || tx_data !== 8'h4C) begin
      n_fail++;
      $display("FAIL single_push: push=%b data=%h want 1/4c", tx_push, tx_data);
    end
    tick();
    n_checks++;
    if (pending !== 4'b0000 || tx_push !== 1'b0 || tx_data !== 8'h4C) begin
      n_fail++;
      $display("FAIL single_after: pend=%b push=%b data=%h want 0000/0/4c",
               pending, tx_push, tx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_codes [4];
    logic       exp_push;
    exp_codes = '{8'h55, 8'h44, 8'h4C, 8'h52};
    do_reset();
    btn_pulse = 4'b1111;
    tick();
    btn_pulse = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      exp_push = (c == 2 || c == 4 || c == 6 || c == 8);
      n_checks++;
      if (tx_push !== exp_push) begin
        n_fail++;
        $display("FAIL b2b_push cycle %0d: got %b want %b", c, tx_push, exp_push);
      end
      if (exp_push) begin
        n_checks++;
        if (tx_data !== exp_codes[c/2 - 1]) begin
          n_fail++;
          $display("FAIL b2b_data cycle %0d: got %h want %h", c, tx_data, exp_codes[c/2 - 1]);
        end
      end
    end
    n_checks++;
    if (drop_cnt !== 8'd0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_end: drop=%0d pend=%b want 0/0000", drop_cnt, pending);
    end
  endtask

  task automatic test_full_hold();
    do_reset();
    tx_full   = 1'b1;
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (tx_push !== 1'b0 || pending !== 4'b0010) begin
        n_fail++;
        $display("FAIL full_hold %0d: push=%b pend=%b want 0/0010", c, tx_push, pending);
      end
    end
    tx_full = 1'b0;
    #1;
    n_checks++;
    if (tx_push !== 1'b1 || tx_data !== 8'h44) begin
      n_fail++;
      $display("FAIL full_release: push=%b data=%h want 1/44", tx_push, tx_data);
    end
    tick();
    n_checks++;
    if (tx_push !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_after: push=%b pend=%b want 0/0000", tx_push, pending);
    end
  endtask

  task automatic test_multi_drop();
    do_reset();
    tx_full   = 1'b1;
    btn_pulse = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (drop_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL multi_drop4: got %0d want 4", drop_cnt);
    end
    btn_pulse = 4'b0110;
    tick();
    n_checks++;
    if (drop_cnt !== 8'd6) begin
      n_fail++;
      $display("FAIL multi_drop6: got %0d want 6", drop_cnt);
    end
    tx_full   = 1'b0;
    btn_pulse = 4'b0001;
    #1;
    n_checks++;
    if (tx_push !== 1'b1 || tx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL same_cycle_push: push=%b data=%h want 1/55", tx_push, tx_data);
    end
    tick();
    btn_pulse = '0;
    n_checks++;
    if (pending !== 4'b1111 || drop_cnt !== 8'd6) begin
      n_fail++;
      $display("FAIL same_cycle_rearm: pend=%b drop=%0d want 1111/6", pending, drop_cnt);
    end
    tick();
    n_checks++;
    if (tx_push !== 1'b1 || tx_data !== 8'h44) begin
      n_fail++;
      $display("FAIL rr_next: push=%b data=%h want 1/44", tx_push, tx_data);
    end
  endtask

  task automatic test_drop_sat();
    logic [7:0] exp_drop;
    do_reset();
    tx_full   = 1'b1;
    btn_pulse = 4'b0001;
    tick();
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        exp_drop = (n > 255) ? 8'd255 : 8'(n);
        n_checks++;
        if (drop_cnt !== exp_drop) begin
          n_fail++;
          $display("FAIL drop_sat after %0d: got %0d want %0d", n, drop_cnt, exp_drop);
        end
      end
    end
    btn_pulse = '0;
    n_checks++;
    if (pending !== 4'b0001 || tx_push !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_sat_state: pend=%b push=%b want 0001/0", pending, tx_push);
    end
  endtask

  task automatic test_rst_mid_push();
    do_reset();
    btn_pulse = 4'b0001;
    tick();
    tick();
    btn_pulse = '0;
    n_checks++;
    if (tx_push !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_rst: push=%b drop=%0d want 1/1", tx_push, drop_cnt);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (tx_push !== 1'b0 || pending !== 4'b0000 || drop_cnt !== 8'd0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst: push=%b pend=%b drop=%0d data=%h want 0/0000/0/00",
               tx_push, pending, drop_cnt, tx_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (tx_push !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_discard: push=%b pend=%b want 0/0000", tx_push, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_hold();
    test_multi_drop();
    test_drop_sat();
    test_rst_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
